// File: rtl/id_hazard_ctrl.sv
// id_hazard_ctrl: ID-stage issue control; tracks EX/MEM/WB destinations, stalls on load-use,
// and selects the RD1/RD2 forwarding sources.
module id_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [4:0]       id_wr,
  input  logic             id_we,
  input  logic             id_is_load,
  input  logic             ex_ready,
  input  logic             flush,
  output logic             id_issue,
  output logic             id_stall,
  output logic [1:0]       fwd_rs,
  output logic [1:0]       fwd_rt,
  output logic [CNT_W-1:0] stall_cnt
);
  typedef struct packed {
    logic       v;
    logic [4:0] wr;
    logic       ld;
  } slot_t;

  slot_t ex_q, mem_q, wb_q, ex_d, mem_d, wb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic hz_rs, hz_rt, lu;

  function automatic logic writes(input slot_t s, input logic [4:0] r);
    return s.v && s.wr == r && r != 5'd0;
  endfunction

  // Youngest producer wins: EX, then MEM, then WB (covers same-cycle regfile write/read).
  function automatic logic [1:0] sel(input logic use_r, input logic [4:0] r,
                                     input slot_t e, input slot_t m, input slot_t w);
    return !use_r ? 2'd0 : writes(e, r) ? 2'd1 : writes(m, r) ? 2'd2 : writes(w, r) ? 2'd3 : 2'd0;
  endfunction

  always_comb begin
    hz_rs    = id_use_rs && writes(ex_q, id_rs) && ex_q.ld;
    hz_rt    = id_use_rt && writes(ex_q, id_rt) && ex_q.ld;
    lu       = id_valid && (hz_rs || hz_rt);
    id_issue = id_valid && ex_ready && !flush && !lu;
    id_stall = id_valid && (!ex_ready || lu) && !flush;
    fwd_rs   = sel(id_use_rs, id_rs, ex_q, mem_q, wb_q);
    fwd_rt   = sel(id_use_rt, id_rt, ex_q, mem_q, wb_q);
    ex_d     = ex_q;
    mem_d    = mem_q;
    wb_d     = wb_q;
    if (flush) begin
      ex_d  = '0;
      mem_d = '0;
      wb_d  = mem_q;
    end else if (ex_ready) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      ex_d  = id_issue ? slot_t'{v: id_we, wr: id_wr, ld: id_is_load} : '0;
    end
    cnt_d = (lu && ex_ready && !flush && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;
endmodule

// File: tb/tb_id_hazard_ctrl.sv
// tb_id_hazard_ctrl: directed and random checks against an in-flight instruction list model.
module tb_id_hazard_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic id_valid, id_use_rs, id_use_rt, id_we, id_is_load, ex_ready, flush;
  logic [4:0] id_rs, id_rt, id_wr;
  logic id_issue, id_stall, id_issue2, id_stall2;
  logic [1:0] fwd_rs, fwd_rt, fwd_rs2, fwd_rt2;
  logic [15:0] stall_cnt;
  logic [1:0] stall_cnt2;

  int checks = 0, errors = 0;

  typedef struct {
    bit v;
    int wr;
    bit ld;
  } ent_t;
  ent_t pipe[3];  // [0] is the instruction now in EX, [2] the one in WB
  int cnt;

  id_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr(id_wr), .id_we(id_we),
    .id_is_load(id_is_load), .ex_ready(ex_ready), .flush(flush), .id_issue(id_issue),
    .id_stall(id_stall), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .stall_cnt(stall_cnt)
  );

  id_hazard_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr(id_wr), .id_we(id_we),
    .id_is_load(id_is_load), .ex_ready(ex_ready), .flush(flush), .id_issue(id_issue2),
    .id_stall(id_stall2), .fwd_rs(fwd_rs2), .fwd_rt(fwd_rt2), .stall_cnt(stall_cnt2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_fwd(input bit use_r, input int r);
    if (!use_r || r == 0) return 0;
    for (int i = 0; i < 3; i++)
      if (pipe[i].v && pipe[i].wr == r) return i + 1;
    return 0;
  endfunction

  function automatic bit m_lu();
    bit a, b;
    a = id_use_rs && m_fwd(1, int'(id_rs)) == 1 && pipe[0].ld;
    b = id_use_rt && m_fwd(1, int'(id_rt)) == 1 && pipe[0].ld;
    return id_valid && (a || b);
  endfunction

  function automatic bit m_issue();
    return id_valid && ex_ready && !flush && !m_lu();
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 3; i++) pipe[i] = '{v: 0, wr: 0, ld: 0};
    cnt = 0;
  endtask

  task automatic set_in(input logic v, input int rs, input int rt, input logic urs, input logic urt,
                        input int wr, input logic we, input logic ld, input logic rdy, input logic fl);
    id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_use_rs = urs; id_use_rt = urt;
    id_wr = 5'(wr); id_we = we; id_is_load = ld; ex_ready = rdy; flush = fl;
    #1;
    chk("issue", int'(id_issue), int'(m_issue()));
    chk("stall", int'(id_stall), int'(id_valid && (!ex_ready || m_lu()) && !flush));
    chk("fwd_rs", int'(fwd_rs), m_fwd(id_use_rs, int'(id_rs)));
    chk("fwd_rt", int'(fwd_rt), m_fwd(id_use_rt, int'(id_rt)));
    chk("cnt", int'(stall_cnt), cnt);
    chk("cnt_sat", int'(stall_cnt2), cnt > 3 ? 3 : cnt);
  endtask

  task automatic adv();
    ent_t n;
    bit iss, lu;
    iss = m_issue();
    lu = m_lu();
    @(posedge clk);
    if (lu && ex_ready && !flush) cnt++;
    if (flush) begin
      pipe[2] = pipe[1];
      pipe[1] = '{v: 0, wr: 0, ld: 0};
      pipe[0] = '{v: 0, wr: 0, ld: 0};
    end else if (ex_ready) begin
      n = iss ? '{v: id_we, wr: int'(id_wr), ld: id_is_load} : '{v: 0, wr: 0, ld: 0};
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = n;
    end
    @(negedge clk);
  endtask

  task automatic nop();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    adv();
  endtask

  int c0;

  initial begin
    m_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("rst_issue", int'(id_issue), 0);
    chk("rst_fwd", int'(fwd_rs), 0);
    adv();

    // back-to-back ALU forwarding
    set_in(1, 1, 1, 1, 1, 3, 1, 0, 1, 0); adv();
    set_in(1, 3, 1, 1, 1, 4, 1, 0, 1, 0);
    chk("alu_fwd1", int'(fwd_rs), 1); chk("alu_nostall", int'(id_stall), 0); adv();
    set_in(1, 1, 3, 1, 1, 6, 1, 0, 1, 0);
    chk("alu_fwd2", int'(fwd_rt), 2); adv();
    repeat (3) nop();

    // load-use
    c0 = cnt;
    set_in(1, 0, 0, 0, 0, 8, 1, 1, 1, 0); adv();
    set_in(1, 8, 1, 1, 0, 7, 1, 0, 1, 0);
    chk("lu_stall", int'(id_stall), 1); chk("lu_noissue", int'(id_issue), 0); adv();
    set_in(1, 8, 1, 1, 0, 7, 1, 0, 1, 0);
    chk("lu_cnt", int'(stall_cnt), c0 + 1); chk("lu_issue", int'(id_issue), 1);
    chk("lu_fwd", int'(fwd_rs), 2); adv();
    repeat (3) nop();

    // forwarding priority and r0
    repeat (3) begin set_in(1, 0, 0, 0, 0, 2, 1, 0, 1, 0); adv(); end
    set_in(1, 2, 0, 1, 0, 0, 0, 0, 1, 0); chk("prio_ex", int'(fwd_rs), 1);
    set_in(1, 0, 0, 1, 0, 0, 0, 0, 1, 0); chk("prio_r0", int'(fwd_rs), 0);
    set_in(1, 0, 0, 0, 0, 0, 1, 1, 1, 0); adv();  // load to r0
    set_in(1, 0, 0, 1, 1, 1, 1, 0, 1, 0); chk("r0_nohz", int'(id_stall), 0); adv();
    repeat (3) nop();

    // flush beats load-use
    c0 = cnt;
    set_in(1, 0, 0, 0, 0, 9, 1, 1, 1, 0); adv();
    set_in(1, 9, 0, 1, 0, 1, 1, 0, 1, 1);
    chk("fl_issue", int'(id_issue), 0); chk("fl_stall", int'(id_stall), 0); adv();
    set_in(1, 9, 0, 1, 0, 1, 1, 0, 1, 0);
    chk("fl_cnt", int'(stall_cnt), c0); chk("fl_fwd", int'(fwd_rs), 0); adv();

    // backpressure holds slots, stall without counting
    set_in(1, 0, 0, 0, 0, 12, 1, 1, 1, 0); adv();
    c0 = cnt;
    repeat (4) begin
      set_in(1, 12, 0, 1, 0, 1, 1, 0, 0, 0);
      chk("bp_stall", int'(id_stall), 1); chk("bp_fwd", int'(fwd_rs), 1); adv();
    end
    chk("bp_cnt", int'(stall_cnt), c0);
    repeat (3) nop();

    // five load-use stalls for saturation of the narrow counter
    repeat (5) begin
      set_in(1, 0, 0, 0, 0, 10, 1, 1, 1, 0); adv();
      set_in(1, 0, 10, 0, 1, 0, 0, 0, 1, 0); adv();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); chk("sat", int'(stall_cnt2), 3);

    // reset mid-stall with a load to r5 in EX
    set_in(1, 0, 0, 0, 0, 5, 1, 1, 1, 0); adv();
    set_in(1, 5, 0, 1, 0, 1, 1, 0, 1, 0); chk("pre_rst_stall", int'(id_stall), 1);
    #2 rst_n = 1'b0;
    #1 m_reset();
    chk("rst_async_cnt", int'(stall_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    set_in(1, 5, 0, 1, 0, 1, 1, 0, 1, 0);
    chk("rst_stall", int'(id_stall), 0); chk("rst_iss", int'(id_issue), 1);
    adv();

    // random
    for (int i = 0; i < 3000; i++) begin
      set_in($urandom_range(0, 5) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
             $urandom_range(0, 3) != 0, $urandom_range(0, 1),
             $urandom_range(0, 4) != 0, $urandom_range(0, 9) == 0);
      adv();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
